pwm_decoder: RTL
================

Name: pwm_decoder

Overview:
- Receive side of the team's PWM output channel: samples one external PWM waveform and measures its period and high time in system clocks.
- Converts the measurement to an 8-bit duty code on the transmitter's scale: 0x00 = always low, 0xFF = always high, otherwise floor(high*256/period).
- Used for loopback self-test of the PWM outputs and for capturing external PWM inputs.
- Sits beside the PWM generator and feeds the register file.

Parameters:
- CNT_W, 16, width of the period/high counters and of period_out.
- TIMEOUT_CYC, 8192, cycles without a rising edge before the input is declared static. Legal range: 16 to 2^CNT_W-1. Default is above 2x the nominal 3328-cycle generator period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  decoder enable; low forces IDLE
- pwm_in  in  1  asynchronous PWM input
- duty_out  out  8  last duty code
- period_out  out  CNT_W  last measured period in clocks; 0 when static
- valid  out  1  one-cycle pulse when duty_out/period_out update
- static_lvl  out  1  1 = last result came from timeout (constant input)
- locked  out  1  1 = at least one periodic result since entering MEASURE
- overrun  out  1  sticky; a period ended while the divider was busy

Behaviour:
- Reset (async, rst_n low):
  - duty_out=0, period_out=0, valid=0, static_lvl=0, locked=0, overrun=0.
  - FSM=IDLE; synchroniser and counters cleared.
- Input path:
  - 2-flop synchroniser to s, plus s_d (s delayed one cycle).
  - Rising edge detect (rise) = s & ~s_d.
  - Input-pin-to-s latency is 2 clocks.
- Counters:
  - per_cnt and hi_cnt are CNT_W bits.
  - On rise: per_cnt<=1, hi_cnt<=1.
  - Otherwise: per_cnt +1 (saturating), and hi_cnt +1 when s=1.
  - Value in per_cnt on a rise cycle = P, the clocks since the previous rise. Value in hi_cnt = H, with 1<=H<=P-1.
- FSM states: IDLE, MEASURE, DIVIDE, STATIC.
  - IDLE: counters held at 0. On en & rise -> MEASURE (counters start). No result is produced.
  - MEASURE, on rise: latch P,H -> DIVIDE.
  - MEASURE, on per_cnt==TIMEOUT_CYC (checked before rise): -> STATIC and emit a static result.
  - DIVIDE: restoring divider, 8 cycles, one quotient bit per cycle.
    - Numerator {H,8'h00}, denominator P; quotient always fits 8 bits.
    - Counters keep running through DIVIDE, so no measurement time is lost.
    - After the 8th iteration: duty_out<=quotient, period_out<=P, static_lvl<=0, locked<=1, valid=1 for one cycle, then -> MEASURE.
    - Latency: valid is high exactly 9 cycles after the rise cycle.
  - DIVIDE, rise during it:
    - Counters restart normally.
    - That period's result is dropped and overrun<=1.
    - The current division completes.
    - The FSM returns to MEASURE and waits for the next rise.
  - DIVIDE, timeout during it: evaluated on return to MEASURE.
  - Static result (MEASURE -> STATIC):
    - duty_out<= s ? 8'hFF : 8'h00; period_out<=0; static_lvl<=1; locked<=0.
    - valid pulses once, in the cycle after per_cnt hits TIMEOUT_CYC.
  - STATIC: no further results; per_cnt held. On rise -> MEASURE (counters restart); no result at that edge.
- en low, any state:
  - Next cycle FSM=IDLE, counters=0, any division in flight is aborted (no valid), locked<=0, overrun<=0.
  - duty_out, period_out and static_lvl hold.
- Simultaneous rise and timeout on the same cycle: rise wins (periodic measurement).
- per_cnt saturates at 2^CNT_W-1 and never wraps. Timeout fires before saturation because TIMEOUT_CYC<2^CNT_W.
- Async reset mid-DIVIDE: all state cleared immediately; no valid.

Test Plan:
- Generator-like waveform, P=3328, H=1664 (code 128 at div 13), en=1 -> first valid at the second rise+9 cycles; duty_out=128, period_out=3328, locked=1, static_lvl=0; repeats every 3328 cycles.
- P=3328, H=13 -> duty_out=1. P=3328, H=3315 -> duty_out=255, static_lvl=0.
- Odd small waveform, H=3, P=17 -> duty_out=floor(768/17)=45, period_out=17, valid every 17 cycles.
- pwm_in held high 10000 cycles after locking -> valid once at TIMEOUT_CYC after the last rise: duty_out=0xFF, period_out=0, static_lvl=1, locked=0. Held low instead -> duty_out=0x00. Toggling again resumes periodic results.
- H=2, P=6 (period shorter than 9-cycle divide) -> overrun=1 and alternate periods reported: duty_out=85, period_out=6. en low for one cycle clears overrun and locked.
- Assert rst_n low 4 cycles after a rise (mid-DIVIDE) -> no valid; all outputs 0; recovery requires two rises before the next valid.

Source files
------------

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures the period and high time of an external PWM input in
// system clocks and converts them to an 8-bit duty code on the generator's scale.
module pwm_decoder #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 8192
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [7:0]       duty_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             static_lvl,
  output logic             locked,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE,
    STATIC
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             sync_dly_q, sync_dly_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       quo_q, quo_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             static_q, static_d;
  logic             locked_q, locked_d;
  logic             overrun_q, overrun_d;

  logic             rise;
  logic [CNT_W-1:0] per_inc;
  logic [CNT_W-1:0] hi_inc;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W:0]   rem_diff;
  logic             rem_ge;
  logic [CNT_W-1:0] rem_nx;
  logic [7:0]       quo_nx;

  // Edge detect, saturating counters and one restoring-divider step.
  // The remainder stays below the denominator, so one extra bit is enough.
  always_comb begin
    rise     = sync_q & ~sync_dly_q;
    per_inc  = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + CNT_ONE;
    hi_inc   = (sync_q && (hi_cnt_q != '1)) ? hi_cnt_q + CNT_ONE : hi_cnt_q;
    rem_sh   = {rem_q, 1'b0};
    rem_diff = rem_sh - {1'b0, den_q};
    rem_ge   = (rem_sh >= {1'b0, den_q});
    rem_nx   = rem_ge ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
    quo_nx   = {quo_q[6:0], rem_ge};
  end

  always_comb begin
    state_d    = state_q;
    meta_d     = pwm_in;
    sync_d     = meta_q;
    sync_dly_d = sync_q;
    per_cnt_d  = per_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    den_d      = den_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    bit_d      = bit_q;
    duty_d     = duty_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    static_d   = static_q;
    locked_d   = locked_q;
    overrun_d  = overrun_q;

    if (!en) begin
      state_d   = IDLE;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      bit_d     = '0;
      locked_d  = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          if (rise) begin
            state_d   = MEASURE;
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
          end
        end

        // Rise is tested first so a coincident timeout still yields a period.
        // >= rather than == lets a timeout crossed during DIVIDE fire here.
        MEASURE: begin
          if (rise) begin
            den_d     = per_cnt_q;
            rem_d     = hi_cnt_q;
            quo_d     = '0;
            bit_d     = '0;
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
            state_d   = DIVIDE;
          end else if (per_cnt_q >= TIMEOUT) begin
            duty_d   = sync_q ? 8'hFF : 8'h00;
            period_d = '0;
            static_d = 1'b1;
            locked_d = 1'b0;
            valid_d  = 1'b1;
            state_d  = STATIC;
          end else begin
            per_cnt_d = per_inc;
            hi_cnt_d  = hi_inc;
          end
        end

        DIVIDE: begin
          if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
            overrun_d = 1'b1;
          end else begin
            per_cnt_d = per_inc;
            hi_cnt_d  = hi_inc;
          end
          rem_d = rem_nx;
          quo_d = quo_nx;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            duty_d   = quo_nx;
            period_d = den_q;
            static_d = 1'b0;
            locked_d = 1'b1;
            valid_d  = 1'b1;
            state_d  = MEASURE;
          end
        end

        STATIC: begin
          if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
            state_d   = MEASURE;
          end
        end

        default: begin
          state_d   = IDLE;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      bit_q      <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      static_q   <= 1'b0;
      locked_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      bit_q      <= bit_d;
      duty_q     <= duty_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      static_q   <= static_d;
      locked_q   <= locked_d;
      overrun_q  <= overrun_d;
    end
  end

  assign duty_out   = duty_q;
  assign period_out = period_q;
  assign valid      = valid_q;
  assign static_lvl = static_q;
  assign locked     = locked_q;
  assign overrun    = overrun_q;

endmodule
